program_loader: RTL

PROGRAM_LOADER -- requirements
Module: program_loader

---
 rtl/program_loader.sv | 115 +++++++++++
 1 files changed

// File: rtl/program_loader.sv
// Serial program loader: parses HEADER/LEN/payload/CHK frames from a byte
// stream, unpacks two opcodes per byte into program memory, verifies checksum.
module program_loader #(
    parameter int          ADDR_WIDTH   = 8,
    parameter int          OPCODE_WIDTH = 4,
    parameter logic [7:0]  HEADER       = 8'hA5
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    in_valid,
    input  logic [7:0]              in_data,
    output logic                    in_ready,
    output logic                    mem_we,
    output logic [ADDR_WIDTH-1:0]   mem_addr,
    output logic [OPCODE_WIDTH-1:0] mem_wdata,
    output logic                    cpu_hold,
    output logic                    done,
    output logic                    error
);

    // Handshake: a byte transfers on a rising edge where in_valid && in_ready;
    // in_ready never depends on in_valid, and in_valid may be held high.
    typedef enum logic [2:0] {
        S_IDLE, S_LEN, S_DATA, S_WR_LO, S_WR_HI, S_CHK, S_ERR
    } state_t;

    localparam logic [ADDR_WIDTH:0] FULL_N = {1'b1, {ADDR_WIDTH{1'b0}}};

    state_t              state;
    state_t              state_next;
    logic [ADDR_WIDTH:0] n_q;
    logic [ADDR_WIDTH:0] cnt_q;
    logic [ADDR_WIDTH:0] cnt_inc;
    logic [ADDR_WIDTH:0] len_n;
    logic [7:0]          byte_q;
    logic [7:0]          sum_q;
    logic                error_q;
    logic                done_q;
    logic                fire;
    logic                is_header;
    logic                chk_ok;
    logic                last_opcode;

    assign fire        = in_valid && in_ready;
    assign is_header   = (in_data == HEADER);
    assign chk_ok      = (in_data == sum_q);
    assign cnt_inc     = cnt_q + 1'b1;
    // The counter is one bit wider than the address so N = 2^ADDR_WIDTH ends cleanly.
    assign last_opcode = (cnt_inc == n_q);
    assign len_n       = (in_data == 8'd0) ? FULL_N : (ADDR_WIDTH+1)'(in_data);

    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= S_IDLE;
            n_q     <= '0;
            cnt_q   <= '0;
            byte_q  <= '0;
            sum_q   <= '0;
            error_q <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state  <= state_next;
            done_q <= (state == S_CHK) && fire && chk_ok;
            case (state)
                S_LEN: if (fire) begin
                    n_q   <= len_n;
                    cnt_q <= '0;
                    sum_q <= '0;
                end
                S_DATA: if (fire) begin
                    byte_q <= in_data;
                    sum_q  <= sum_q + in_data;
                end
                S_WR_LO, S_WR_HI: cnt_q <= cnt_inc;
                S_CHK: if (fire && !chk_ok) error_q <= 1'b1;
                S_ERR: if (fire && is_header) error_q <= 1'b0;
                default: ;
            endcase
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            S_IDLE:  if (fire && is_header) state_next = S_LEN;
            S_LEN:   if (fire) state_next = S_DATA;
            S_DATA:  if (fire) state_next = S_WR_LO;
            S_WR_LO: state_next = last_opcode ? S_CHK : S_WR_HI;
            S_WR_HI: state_next = last_opcode ? S_CHK : S_DATA;
            S_CHK:   if (fire) state_next = chk_ok ? S_IDLE : S_ERR;
            S_ERR:   if (fire && is_header) state_next = S_LEN;
            default: state_next = S_IDLE;
        endcase
    end

    // Outputs are forced low combinationally in a reset cycle so an aborted write never lands.
    always_comb begin
        in_ready  = 1'b0;
        mem_we    = 1'b0;
        mem_addr  = cnt_q[ADDR_WIDTH-1:0];
        mem_wdata = byte_q[OPCODE_WIDTH-1:0];
        cpu_hold  = 1'b0;
        done      = 1'b0;
        error     = 1'b0;
        if (!reset) begin
            in_ready = (state != S_WR_LO) && (state != S_WR_HI);
            mem_we   = (state == S_WR_LO) || (state == S_WR_HI);
            cpu_hold = (state != S_IDLE);
            done     = done_q;
            error    = error_q;
            if (state == S_WR_HI) mem_wdata = byte_q[7 -: OPCODE_WIDTH];
        end
    end

endmodule
